// File: rtl/between_pkg.sv
// Shared definitions for the 8-wire inter-board link (transmit and receive sides).
// Contents: data width, handshake state encoding, and the line-to-byte mapping.
package between_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_e;

  // t0 is the MSB of the byte, t7 the LSB.
  function automatic logic [DATA_W-1:0] lines_to_byte(
    input logic t0, input logic t1, input logic t2, input logic t3,
    input logic t4, input logic t5, input logic t6, input logic t7
  );
    return {t0, t1, t2, t3, t4, t5, t6, t7};
  endfunction

endpackage

// File: rtl/between_fifo.sv
// First-word-fall-through byte FIFO for the link receive side.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, din, full   write side; push ignored while full
//   pop, dout, empty  read side; dout holds the head byte, pop ignored while empty
//   level             number of bytes held
module between_fifo
  import between_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  output logic                     full,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  rd_next_c;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              push_c, pop_c;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign push_c = push && !full;
  assign pop_c  = pop && !empty;
  assign dout   = dout_q;
  assign level  = count_q;

  // Pointer/count update and look-ahead of the head byte so dout is a flop.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    rd_next_c = rd_ptr_q + PTR_W'(1);

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_next_c;

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Next head: the byte behind the popped one, or the incoming byte if the
    // FIFO would otherwise have been empty.
    if (pop_c) begin
      if (count_q > CNT_W'(1)) dout_d = mem_q[rd_next_c];
      else if (push_c)         dout_d = din;
    end else if (push_c && empty) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/between_to_in.sv
// Receive side of the 8-wire inter-board link: four-phase handshake on
// tsent/trecieve, one byte captured per tsent high phase into a FWFT FIFO,
// acknowledge withheld while the FIFO is full.
// Optional macro BETWEEN_RX_SYNC_EN: pass tsent through a two-flop synchronizer
// (needed when the sender is on another board or clock).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   t0..t7                link data lines (t0 = MSB)
//   tsent                 sender strobe
//   trecieve              acknowledge to the sender
//   data_out, data_valid  head-of-FIFO byte and its valid flag
//   data_ready            consumer accepts data_out
//   level                 number of bytes held
module between_to_in
  import between_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    t0,
  input  logic                    t1,
  input  logic                    t2,
  input  logic                    t3,
  input  logic                    t4,
  input  logic                    t5,
  input  logic                    t6,
  input  logic                    t7,
  input  logic                    tsent,
  output logic                    trecieve,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic [$clog2(DEPTH):0]  level
);

  logic   tsent_s;
  state_e state_q, state_d;
  logic   trecieve_q, trecieve_d;
  logic   push_c, pop_c, full_c, empty_c;

`ifdef BETWEEN_RX_SYNC_EN
  // Two-flop synchronizer on the strobe; data lines are stable by the time it lands.
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], tsent};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign tsent_s = sync_q[1];
`else
  assign tsent_s = tsent;
`endif

  // Handshake: push once on entry to ACK, hold ACK until the strobe drops.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    if (state_q == IDLE) begin
      if (tsent_s && !full_c) begin
        push_c  = 1'b1;
        state_d = ACK;
      end
    end else begin
      if (!tsent_s) state_d = IDLE;
    end
    trecieve_d = (state_d == ACK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      trecieve_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trecieve_q <= trecieve_d;
    end
  end

  assign trecieve   = trecieve_q;
  assign data_valid = !empty_c;
  assign pop_c      = data_ready && !empty_c;

  between_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .din   (lines_to_byte(t0, t1, t2, t3, t4, t5, t6, t7)),
    .full  (full_c),
    .pop   (pop_c),
    .dout  (data_out),
    .empty (empty_c),
    .level (level)
  );

endmodule

// File: tb/tb_between_to_in.sv
// Self-checking bench for between_to_in: a handshaking sender, a random or
// directed consumer, and a queue-based reference model of the link rules.
`timescale 1ns/1ps
module tb_between_to_in;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
`ifdef BETWEEN_RX_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       tx_byte = 8'h00;
  logic             tsent = 1'b0;
  logic             data_ready = 1'b0;
  logic             trecieve;
  logic             data_valid;
  logic [7:0]       data_out;
  logic [LVL_W-1:0] level;

  always #5 clk = ~clk;

  between_to_in #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .t0         (tx_byte[7]),
    .t1         (tx_byte[6]),
    .t2         (tx_byte[5]),
    .t3         (tx_byte[4]),
    .t4         (tx_byte[3]),
    .t5         (tx_byte[2]),
    .t6         (tx_byte[1]),
    .t7         (tx_byte[0]),
    .tsent      (tsent),
    .trecieve   (trecieve),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .level      (level)
  );

  // Reference model state
  logic [7:0] exp_q[$];
  bit         phase_done = 1'b0;   // byte already taken in this strobe-high phase
  bit [1:0]   sync_hist  = 2'b00;  // strobe delay line when synchronized
  bit         rand_ready = 1'b0;
  int         n_checks   = 0;
  int         n_pass     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock edge of the link rules, using the inputs present at that edge.
  function automatic void model_step();
    bit ts;
    bit do_push;
    bit do_pop;
    if (rst) begin
      exp_q.delete();
      phase_done = 1'b0;
      sync_hist  = 2'b00;
      return;
    end
    ts        = (SYNC_LAT == 0) ? tsent : sync_hist[1];
    sync_hist = {sync_hist[0], tsent};
    do_pop    = data_ready && (exp_q.size() != 0);
    do_push   = ts && !phase_done && (exp_q.size() < DEPTH);
    if (!ts)          phase_done = 1'b0;
    else if (do_push) phase_done = 1'b1;
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(tx_byte);
  endfunction

  // Advance one clock and compare every output against the model.
  task automatic tick();
    if (rand_ready) data_ready = ($urandom_range(0, 3) == 0);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("trecieve", 32'(trecieve), 32'(phase_done));
    check("data_valid", 32'(data_valid), 32'(exp_q.size() != 0));
    check("level", 32'(level), 32'(exp_q.size()));
    if (exp_q.size() != 0) check("data_out", 32'(data_out), 32'(exp_q[0]));
  endtask

  // Full four-phase transfer of one byte, holding tsent `hold` extra cycles.
  task automatic send(input logic [7:0] b, input int hold);
    int n;
    tx_byte = b;
    tsent   = 1'b1;
    n = 0;
    while (!trecieve && n < 500) begin tick(); n++; end
    check("ack_rise", 32'(trecieve), 32'(1));
    repeat (hold) tick();
    tsent = 1'b0;
    n = 0;
    while (trecieve && n < 500) begin tick(); n++; end
    check("ack_fall", 32'(trecieve), 32'(0));
  endtask

  task automatic drain();
    int n;
    data_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    tick();
    check("drained_level", 32'(level), 32'(0));
    data_ready = 1'b0;
  endtask

  initial begin
    int lat;

    // Reset state
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_valid", 32'(data_valid), 32'(0));
    rst = 1'b0;
    tick();

    // Reset pulse during ACK drops trecieve at once; the word is recaptured after release
    tx_byte = 8'h3C;
    tsent   = 1'b1;
    repeat (2 + SYNC_LAT) tick();
    check("pre_rst_ack", 32'(trecieve), 32'(1));
    #2 rst = 1'b1;
    #1 check("rst_async_drop", 32'(trecieve), 32'(0));
    tick();
    rst = 1'b0;
    repeat (2 + SYNC_LAT) tick();
    check("recapture_level", 32'(level), 32'(1));
    check("recapture_data", 32'(data_out), 32'(8'h3C));
    tsent = 1'b0;
    repeat (2 + SYNC_LAT) tick();
    drain();

    // Single 0xA5 with strobe held high: latency and exactly one push
    tx_byte = 8'hA5;
    tsent   = 1'b1;
    lat = 0;
    while (!trecieve && lat < 50) begin tick(); lat++; end
    check("ack_latency", 32'(lat), 32'(1 + SYNC_LAT));
    repeat (10) tick();
    check("hold_level", 32'(level), 32'(1));
    check("hold_data", 32'(data_out), 32'(8'hA5));
    check("hold_valid", 32'(data_valid), 32'(1));
    check("hold_ack", 32'(trecieve), 32'(1));
    tsent = 1'b0;
    lat = 0;
    while (trecieve && lat < 50) begin tick(); lat++; end
    check("drop_latency", 32'(lat), 32'(1 + SYNC_LAT));
    drain();

    // Fill to DEPTH, fifth byte stalls until one pop frees space
    for (int i = 1; i <= 4; i++) send(8'(i), 0);
    tx_byte = 8'h05;
    tsent   = 1'b1;
    repeat (8) tick();
    check("full_no_ack", 32'(trecieve), 32'(0));
    check("full_level", 32'(level), 32'(4));
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check("pop_level", 32'(level), 32'(3));
    check("pop_head", 32'(data_out), 32'(8'h02));
    tick();
    check("refill_level", 32'(level), 32'(4));
    check("refill_ack", 32'(trecieve), 32'(1));
    tsent = 1'b0;
    repeat (2 + SYNC_LAT) tick();
    drain();

    // Continuous stream with the consumer always ready
    data_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(8'(i), 0);
    drain();

    // Simultaneous push and pop at level 2
    send(8'h11, 0);
    send(8'h22, 0);
    for (int i = 0; i < 20; i++) begin
      tx_byte = 8'($urandom);
      tsent   = 1'b1;
      repeat (SYNC_LAT) tick();
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("pushpop_level", 32'(level), 32'(2));
      tsent = 1'b0;
      repeat (1 + SYNC_LAT) tick();
    end
    drain();

    // Random bytes, random hold, random consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) send(8'($urandom), int'($urandom_range(0, 3)));
    rand_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
